// File: rtl/pipe_stage_reg_pkg.sv
// Shared pipeline constants and small helpers used by the stage register slice.
package pipe_stage_reg_pkg;

  localparam logic        RstEnable = 1'b1;
  localparam logic        Stop      = 1'b1;
  localparam logic        NoStop    = 1'b0;
  localparam logic [31:0] ZeroWord  = 32'h0000_0000;

  // Pointer width for a ring of `depth` entries; never narrower than one bit.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage : pipe_stage_reg_pkg

// File: rtl/pipe_capture_fifo.sv
// Small synchronous ring-buffer FIFO holding stalled upstream payloads.
// Full pushes without a same-edge pop are ignored; the caller flags overflow.
module pipe_capture_fifo
  import pipe_stage_reg_pkg::*;
#(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr_i,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  logic [WIDTH-1:0]             data_i,
  output logic [WIDTH-1:0]             head_c_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         full_c_o,
  output logic                         empty_c_o
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = ptr_width(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;
  logic             do_push;
  logic             do_pop;

  // Advance a pointer, wrapping at DEPTH (DEPTH need not be a power of two).
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
  endfunction

  assign full_c_o  = (count_q == CNT_W'(DEPTH));
  assign empty_c_o = (count_q == '0);
  assign head_c_o  = mem_q[rd_ptr_q];
  assign count_o   = count_q;

  // Pointer and occupancy next-state; a full FIFO still accepts a push when it pops.
  always_comb begin
    do_pop   = pop_i && !empty_c_o && !clr_i && (rst != RstEnable);
    do_push  = push_i && (!full_c_o || do_pop) && !clr_i && (rst != RstEnable);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Control state register.
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage; entries are only meaningful while counted, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule : pipe_capture_fifo

// File: rtl/pipe_stage_reg.sv
// Pipeline-stage register with valid bit, flush, and an in-order capture FIFO
// that catches upstream results still arriving while this stage is stalled.
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned STALL_W   = 6,
  parameter int unsigned STAGE     = 1,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [STALL_W-1:0]                stall,
  input  logic                              flush,
  input  logic                              in_valid,
  input  logic [ADDR_W-1:0]                 in_pc,
  input  logic [DATA_W-1:0]                 in_data,
  output logic                              out_valid,
  output logic [ADDR_W-1:0]                 out_pc,
  output logic [DATA_W-1:0]                 out_data,
  output logic [$clog2(BUF_DEPTH+1)-1:0]    buf_count,
  output logic                              buf_ovf
);

  localparam int unsigned ENTRY_W = ADDR_W + DATA_W;

  // Reject illegal parameterisations at elaboration.
  generate
    if (STAGE + 2 > STALL_W) begin : g_bad_stage
      $error("pipe_stage_reg: STAGE must satisfy 0 <= STAGE <= STALL_W-2");
    end
    if (BUF_DEPTH < 1 || BUF_DEPTH > 8) begin : g_bad_depth
      $error("pipe_stage_reg: BUF_DEPTH must be in 1..8");
    end
  endgenerate

  logic               su;
  logic               sd;
  logic               fifo_push;
  logic               fifo_pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [ENTRY_W-1:0] fifo_head;
  logic [ADDR_W-1:0]  head_pc;
  logic [DATA_W-1:0]  head_data;
  logic               ovf_evt;

  logic               valid_q, valid_d;
  logic [ADDR_W-1:0]  pc_q,    pc_d;
  logic [DATA_W-1:0]  data_q,  data_d;
  logic               ovf_q,   ovf_d;

  assign su        = stall[STAGE];
  assign sd        = stall[STAGE+1];
  assign head_pc   = fifo_head[DATA_W +: ADDR_W];
  assign head_data = fifo_head[0 +: DATA_W];

  // Capture while upstream is stopped, or behind older buffered entries so
  // a live input never overtakes them; drain one entry per advance.
  always_comb begin
    fifo_push = in_valid && !flush && ((su == Stop) || !fifo_empty);
    fifo_pop  = !flush && (su == NoStop) && !fifo_empty;
    ovf_evt   = fifo_push && fifo_full && !fifo_pop;
  end

  pipe_capture_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (BUF_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (flush),
    .push_i    (fifo_push),
    .pop_i     (fifo_pop),
    .data_i    ({in_pc, in_data}),
    .head_c_o  (fifo_head),
    .count_o   (buf_count),
    .full_c_o  (fifo_full),
    .empty_c_o (fifo_empty)
  );

  // Output next-state: flush, bubble, hold, replay, then live bypass.
  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    data_d  = data_q;
    ovf_d   = ovf_q | ovf_evt;
    if (flush) begin
      valid_d = 1'b0;
      pc_d    = ADDR_W'(ZeroWord);
      data_d  = DATA_W'(ZeroWord);
    end else if (su == Stop) begin
      if (sd == NoStop) begin
        valid_d = 1'b0;
        pc_d    = ADDR_W'(ZeroWord);
        data_d  = DATA_W'(ZeroWord);
      end
    end else if (!fifo_empty) begin
      valid_d = 1'b1;
      pc_d    = head_pc;
      data_d  = head_data;
    end else begin
      valid_d = in_valid;
      pc_d    = in_pc;
      data_d  = in_data;
    end
  end

  // Output and sticky overflow registers.
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      data_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      data_q  <= data_d;
      ovf_q   <= ovf_d;
    end
  end

  assign out_valid = valid_q;
  assign out_pc    = pc_q;
  assign out_data  = data_q;
  assign buf_ovf   = ovf_q;

endmodule : pipe_stage_reg

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: directed vectors queue expected
// payloads; a monitor pops and compares on every advancing valid output.
module tb_pipe_stage_reg;

  localparam logic [5:0] GO   = 6'b000000;
  localparam logic [5:0] BUB  = 6'b000010;
  localparam logic [5:0] HOLD = 6'b000110;

  logic        clk;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_pc;
  logic [31:0] in_data;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_data;
  logic [1:0]  buf_count;
  logic        buf_ovf;

  logic [63:0] exp_q[$];
  int          n_cmp = 0;
  int          n_err = 0;

  pipe_stage_reg #(
    .DATA_W(32), .ADDR_W(32), .STALL_W(6), .STAGE(1), .BUF_DEPTH(2)
  ) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_pc(in_pc), .in_data(in_data),
    .out_valid(out_valid), .out_pc(out_pc), .out_data(out_data),
    .buf_count(buf_count), .buf_ovf(buf_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required finish before 100000");
    $fatal(1, "watchdog expired");
  end

  // Monitor: a new payload is presented only on an advancing edge.
  always @(posedge clk) begin : monitor
    logic        adv;
    logic [63:0] e;
    adv = !rst && !flush && (stall[1] == 1'b0);
    #1;
    if (adv && out_valid) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL out_unexpected: got pc=%h data=%h, required no valid payload", out_pc, out_data);
      end else begin
        e = exp_q.pop_front();
        if ({out_pc, out_data} !== e) begin
          n_err++;
          $display("FAIL out_payload: got pc=%h data=%h, required pc=%h data=%h",
                   out_pc, out_data, e[63:32], e[31:0]);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Apply one cycle of stimulus; exp_push marks payloads that must emerge.
  task automatic drive(input logic [5:0] st, input logic fl, input logic v,
                       input logic [31:0] pc, input logic exp_push);
    stall    = st;
    flush    = fl;
    in_valid = v;
    in_pc    = pc;
    in_data  = ~pc;
    if (fl || rst) exp_q.delete();
    if (exp_push) exp_q.push_back({pc, ~pc});
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b1; stall = GO; flush = 1'b0; in_valid = 1'b0; in_pc = '0; in_data = '0;
    drive(GO, 0, 1, 32'hDEAD, 0);
    drive(GO, 0, 1, 32'hBEEF, 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_pc", out_pc, 0);
    check("rst_out_data", out_data, 0);
    check("rst_buf_count", 32'(buf_count), 0);
    check("rst_buf_ovf", 32'(buf_ovf), 0);
    rst = 1'b0;

    // Straight-line flow
    drive(GO, 0, 1, 32'h100, 1); check("flow_count0", 32'(buf_count), 0);
    drive(GO, 0, 1, 32'h104, 1); check("flow_count1", 32'(buf_count), 0);
    drive(GO, 0, 1, 32'h108, 1); check("flow_count2", 32'(buf_count), 0);

    // Bubble stall capturing two results, then in-order replay
    drive(BUB, 0, 1, 32'h10C, 1);
    check("bub_valid0", 32'(out_valid), 0); check("bub_count0", 32'(buf_count), 1);
    drive(BUB, 0, 1, 32'h110, 1);
    check("bub_valid1", 32'(out_valid), 0); check("bub_count1", 32'(buf_count), 2);
    drive(GO, 0, 1, 32'h114, 1);
    check("rel_count0", 32'(buf_count), 2); check("rel_no_ovf", 32'(buf_ovf), 0);
    drive(GO, 0, 0, 32'h0, 0); check("rel_count1", 32'(buf_count), 1);
    drive(GO, 0, 0, 32'h0, 0); check("rel_count2", 32'(buf_count), 0);
    drive(GO, 0, 0, 32'h0, 0); check("rel_idle_valid", 32'(out_valid), 0);

    // Hold keeps the presented payload
    drive(GO, 0, 1, 32'h200, 1);
    for (int i = 0; i < 3; i++) begin
      drive(HOLD, 0, 0, 32'h0, 0);
      check("hold_pc", out_pc, 32'h200);
      check("hold_valid", 32'(out_valid), 1);
    end
    drive(GO, 0, 0, 32'h0, 0); check("hold_rel_valid", 32'(out_valid), 0);

    // Overflow: third captured input is dropped
    drive(BUB, 0, 1, 32'h300, 1);
    drive(BUB, 0, 1, 32'h304, 1);
    drive(BUB, 0, 1, 32'h308, 0);
    check("ovf_flag", 32'(buf_ovf), 1); check("ovf_count", 32'(buf_count), 2);
    drive(GO, 0, 0, 32'h0, 0);
    drive(GO, 0, 0, 32'h0, 0);
    check("ovf_sticky", 32'(buf_ovf), 1); check("ovf_drained", 32'(buf_count), 0);
    drive(GO, 0, 0, 32'h0, 0); check("ovf_idle_valid", 32'(out_valid), 0);

    // Flush with a full FIFO and a live input
    drive(BUB, 0, 1, 32'h400, 1);
    drive(BUB, 0, 1, 32'h404, 1);
    check("pre_flush_count", 32'(buf_count), 2);
    drive(GO, 1, 1, 32'h408, 0);
    check("flush_valid", 32'(out_valid), 0); check("flush_pc", out_pc, 0);
    check("flush_count", 32'(buf_count), 0); check("flush_ovf_kept", 32'(buf_ovf), 1);
    drive(GO, 0, 0, 32'h0, 0); check("post_flush_valid0", 32'(out_valid), 0);
    drive(GO, 0, 0, 32'h0, 0); check("post_flush_valid1", 32'(out_valid), 0);

    // Reset in the middle of a replay
    drive(BUB, 0, 1, 32'h500, 1);
    drive(BUB, 0, 1, 32'h504, 1);
    drive(GO, 0, 0, 32'h0, 0); check("replay_count", 32'(buf_count), 1);
    rst = 1'b1;
    drive(GO, 0, 0, 32'h0, 0);
    check("mid_rst_valid", 32'(out_valid), 0); check("mid_rst_pc", out_pc, 0);
    check("mid_rst_data", out_data, 0); check("mid_rst_count", 32'(buf_count), 0);
    check("mid_rst_ovf", 32'(buf_ovf), 0);
    rst = 1'b0;
    drive(GO, 0, 0, 32'h0, 0); check("post_rst_valid0", 32'(out_valid), 0);
    drive(GO, 0, 0, 32'h0, 0); check("post_rst_valid1", 32'(out_valid), 0);

    // Recovery and invalid-input bypass
    drive(GO, 0, 1, 32'h600, 1);
    drive(GO, 0, 0, 32'h7777, 0);
    check("inv_valid", 32'(out_valid), 0);
    check("inv_pc", out_pc, 32'h7777);
    check("inv_data", out_data, ~32'h7777);

    check("exp_queue_drained", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_pipe_stage_reg
